// File: rtl/warp_dispatcher_pkg.sv
// Shared types and constants for the warp dispatcher: kernel descriptor,
// core slot states and the lane-mask helper.
package warp_dispatcher_pkg;

   localparam int NUM_SIMD_CORES    = 4;
   localparam int THREAD_COUNT      = 8;
   localparam int LOG2_THREAD_COUNT = 3;
   localparam int FIFO_DEPTH        = 4;

   localparam logic [3:0] NO_WARP = 4'hF;

   typedef struct packed {
      logic [3:0]                   warp_id;
      logic [LOG2_THREAD_COUNT-1:0] num_threads;
      logic [31:0]                  start_pc;
   } kernel_t;

   typedef enum logic [1:0] {
      CORE_IDLE,
      CORE_LAUNCH,
      CORE_BUSY,
      CORE_DONE_PEND
   } core_state_t;

   // Low num_threads lanes set; evaluated at THREAD_COUNT width.
   function automatic logic [THREAD_COUNT-1:0] thread_mask(
      input logic [LOG2_THREAD_COUNT-1:0] num_threads
   );
      return (THREAD_COUNT'(1) << num_threads) - THREAD_COUNT'(1);
   endfunction

endpackage

// File: rtl/warp_dispatcher_kernel_fifo.sv
// Kernel buffer between the scheduler and the dispatcher. A push on a full
// FIFO only lands when a pop frees a slot in the same cycle.
module kernel_fifo
   import warp_dispatcher_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    i_push,
   input  kernel_t i_data,
   input  logic    i_pop,
   output kernel_t o_head,
   output logic    o_full,
   output logic    o_empty
);

   localparam int AW = $clog2(DEPTH);

   kernel_t       r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_wr_en;
   logic          w_rd_en;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_rd_en = i_pop && !o_empty;
   assign w_wr_en = i_push && (!o_full || w_rd_en);
   assign o_head  = r_mem[r_rd_ptr];

   // NOTE: storage is not reset; r_count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/warp_dispatcher.sv
// Buffers scheduler kernels, launches each onto the lowest idle SIMD core,
// and returns completions one per cycle through a registered finish arbiter.
module warp_dispatcher
   import warp_dispatcher_pkg::*;
(
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       i_valid_kernel,
   input  kernel_t                                    i_kernel_in,
   input  logic [NUM_SIMD_CORES-1:0]                  i_core_done,
   output logic [NUM_SIMD_CORES-1:0]                  o_core_launch,
   output logic [NUM_SIMD_CORES-1:0][31:0]            o_core_pc,
   output logic [NUM_SIMD_CORES-1:0][THREAD_COUNT-1:0] o_core_thread_mask,
   output logic [NUM_SIMD_CORES-1:0][3:0]             o_core_warp_id,
   output logic [3:0]                                 o_finished_warp_id,
   output logic                                       o_fifo_full,
   output logic                                       o_overflow
);

   localparam int CW = $clog2(NUM_SIMD_CORES);

   core_state_t r_state      [NUM_SIMD_CORES];
   core_state_t w_state_next [NUM_SIMD_CORES];

   logic [NUM_SIMD_CORES-1:0][31:0]             r_core_pc;
   logic [NUM_SIMD_CORES-1:0][THREAD_COUNT-1:0] r_core_mask;
   logic [NUM_SIMD_CORES-1:0][3:0]              r_core_warp_id;
   logic [3:0]                                  r_finished;
   logic                                        r_overflow;
   logic                                        r_zero_valid;
   logic [3:0]                                  r_zero_warp;

   kernel_t       w_head;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_dispatch;
   logic          w_zero_load;
   logic          w_head_zero;
   logic          w_any_idle;
   logic [CW-1:0] w_idle_idx;
   logic          w_any_pend;
   logic [CW-1:0] w_pend_idx;

   kernel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (i_valid_kernel),
      .i_data  (i_kernel_in),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Descending scan so the lowest matching index is the one left standing.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_any_idle = 1'b0;
      w_idle_idx = '0;
      w_any_pend = 1'b0;
      w_pend_idx = '0;
      for (int i = NUM_SIMD_CORES-1; i >= 0; i--) begin
         if (r_state[i] == CORE_IDLE) begin
            w_any_idle = 1'b1;
            w_idle_idx = CW'(i);
         end
         if (r_state[i] == CORE_DONE_PEND) begin
            w_any_pend = 1'b1;
            w_pend_idx = CW'(i);
         end
      end
   end

   assign w_head_zero = (w_head.num_threads == '0);
   assign w_dispatch  = !w_empty && !w_head_zero && w_any_idle;
   assign w_zero_load = !w_empty && w_head_zero && !r_zero_valid;
   assign w_pop       = w_dispatch || w_zero_load;

   always_comb begin
      o_core_launch = '0;
      for (int i = 0; i < NUM_SIMD_CORES; i++) begin
         w_state_next[i] = r_state[i];
         unique case (r_state[i])
            CORE_IDLE:      if (w_dispatch && w_idle_idx == CW'(i)) w_state_next[i] = CORE_LAUNCH;
            CORE_LAUNCH: begin
               o_core_launch[i] = 1'b1;
               w_state_next[i]  = CORE_BUSY;
            end
            CORE_BUSY:      if (i_core_done[i]) w_state_next[i] = CORE_DONE_PEND;
            CORE_DONE_PEND: if (w_any_pend && w_pend_idx == CW'(i)) w_state_next[i] = CORE_IDLE;
            default:        w_state_next[i] = CORE_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SIMD_CORES; i++) r_state[i] <= CORE_IDLE;
      end else begin
         for (int i = 0; i < NUM_SIMD_CORES; i++) r_state[i] <= w_state_next[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_core_pc      <= '0;
         r_core_mask    <= '0;
         r_core_warp_id <= {NUM_SIMD_CORES{NO_WARP}};
      end else if (w_dispatch) begin
         r_core_pc[w_idle_idx]      <= w_head.start_pc;
         r_core_mask[w_idle_idx]    <= thread_mask(w_head.num_threads);
         r_core_warp_id[w_idle_idx] <= w_head.warp_id;
      end
   end

   // Finish arbiter: DONE_PEND cores outrank the zero-thread retire slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_finished   <= NO_WARP;
         r_zero_valid <= 1'b0;
         r_zero_warp  <= NO_WARP;
         r_overflow   <= 1'b0;
      end else begin
         if (w_any_pend)        r_finished <= r_core_warp_id[w_pend_idx];
         else if (r_zero_valid) r_finished <= r_zero_warp;
         else                   r_finished <= NO_WARP;

         if (w_zero_load) begin
            r_zero_valid <= 1'b1;
            r_zero_warp  <= w_head.warp_id;
         end else if (r_zero_valid && !w_any_pend) begin
            r_zero_valid <= 1'b0;
         end

         if (i_valid_kernel && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign o_core_pc          = r_core_pc;
   assign o_core_thread_mask = r_core_mask;
   assign o_core_warp_id     = r_core_warp_id;
   assign o_finished_warp_id = r_finished;
   assign o_fifo_full        = w_full;
   assign o_overflow         = r_overflow;

endmodule

// File: doc/warp_dispatcher.md
Name: warp_dispatcher

Overview:
Sits directly downstream of warp_scheduler and consumes its valid_kernel/kernel_out stream. Kernels arrive without backpressure, so they are buffered in a small FIFO. Each kernel is launched onto the lowest-index idle SIMD core, and that core is tracked until it signals completion. Completions are returned to warp_scheduler as finished_warp_id, one per cycle, with 4'hF meaning none.

Parameters:
NUM_SIMD_CORES, 4, number of SIMD cores (shared package constant).
THREAD_COUNT, 8, lanes per core; width of the thread mask.
LOG2_THREAD_COUNT, 3, width of kernel_t.num_threads.
FIFO_DEPTH, 4, kernel buffer entries; power of two.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
valid_kernel  in  1  one-cycle strobe; kernel_in is valid
kernel_in  in  kernel_t  fields warp_id[3:0], num_threads[LOG2_THREAD_COUNT-1:0], start_pc[31:0]
core_done  in  [NUM_SIMD_CORES]  one-cycle pulse per core: warp finished
core_launch  out  [NUM_SIMD_CORES]  one-cycle start pulse per core
core_pc  out  32 x NUM_SIMD_CORES  start PC, held while the core is busy
core_thread_mask  out  THREAD_COUNT x NUM_SIMD_CORES  active-lane mask, held while the core is busy
core_warp_id  out  4 x NUM_SIMD_CORES  warp id, held while the core is busy
finished_warp_id  out  4  retired warp id for one cycle; 4'hF = none
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
overflow  out  1  sticky: a kernel was dropped

Behaviour:
- Reset (async, active-high):
  - FIFO empty; every core slot IDLE.
  - core_launch=0; core_pc=0; core_thread_mask=0; core_warp_id=4'hF.
  - finished_warp_id=4'hF; overflow=0; fifo_full=0.
- FIFO:
  - Write on any clock edge where valid_kernel=1.
  - If the FIFO is full and no pop occurs that cycle, the kernel is dropped and overflow is set until reset.
  - A simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Per-core state machine, states IDLE, LAUNCH, BUSY, DONE_PEND:
  - IDLE to LAUNCH: core selected for dispatch. core_pc, core_thread_mask and core_warp_id are registered on that edge.
  - LAUNCH to BUSY: unconditional, after one cycle. core_launch[i]=1 only while in LAUNCH.
  - BUSY to DONE_PEND: on core_done[i].
  - DONE_PEND to IDLE: when the finish arbiter grants this core.
  - core_done in IDLE or LAUNCH is ignored.
- Dispatch:
  - At most one pop per cycle, taken from the FIFO head, to the lowest-index IDLE core.
  - No bypass. A kernel written at edge E is launched no earlier than edge E+1, so core_launch is high in the cycle after E+1.
- Mask arithmetic: core_thread_mask = (1 << num_threads) - 1, computed at THREAD_COUNT width.
- Zero-thread kernel (num_threads=0):
  - Never occupies a core.
  - Popped into a single-entry zero_retire register. The head stalls if that register is already occupied.
- Finish arbiter, registered:
  - Each edge selects the lowest-index DONE_PEND core; failing that, zero_retire; failing that, 4'hF.
  - The selected warp id drives finished_warp_id for exactly one cycle.
  - Ungranted completions wait in DONE_PEND; none are lost.
- A core released by the arbiter at edge E can be dispatched at edge E+1, not at edge E.
- Reset asserted mid-operation discards all queued and in-flight warps, and no finish is reported for them.

Decomposition:
- Shared package (Structs_and_Params.svh):
  - kernel_t.
  - NUM_SIMD_CORES, THREAD_COUNT, LOG2_THREAD_COUNT.
  - New constants FIFO_DEPTH and NO_WARP=4'hF.
  - New enum core_state_t.
- One sub-module: kernel_fifo, a parameterised kernel_t FIFO with push, pop, full, empty and head.
- Arbitration and the per-core state machines stay in the top module.

Test Plan:
- Reset then idle: all outputs at reset values; finished_warp_id=4'hF for 10 cycles.
- Single kernel {warp_id=2, num_threads=4, start_pc=32'hFFFF_FFFE}:
  - core_launch=4'b0001 exactly one cycle, in the cycle after edge E+1.
  - core_thread_mask[0]=8'h0F; core_pc[0]=32'hFFFF_FFFE.
  - core_done[0] pulse, then finished_warp_id=2 for one cycle.
- Five kernels, one per cycle, with all cores busy and never completing:
  - Four launch, to cores 0..3 in order.
  - The fifth is held in the FIFO (fifo_full=0, occupancy 1).
  - It dispatches to core 1 one cycle after core 1 is reported finished.
- Eight back-to-back kernels with cores busy: fifo_full=1 after four; kernels 5..8 dropped; overflow=1 and stays set until reset.
- Simultaneous core_done on cores 3 and 1 in the same cycle: finished_warp_id shows core 1's warp, then core 3's warp, on consecutive cycles.
- Zero-thread kernel {warp_id=5, num_threads=0}: no core_launch; finished_warp_id=5 within 3 cycles. Assert rst while core 0 is BUSY: finished_warp_id=4'hF and all state is cleared immediately.
